set_multicycle_path_param: RTL

Parametrised multicycle-path benchmark block in a single clock domain. Each lane carries one WIDTH-bit word along a launch register, a per-lane combinational "through" stage and a capture register. The capture register is enabled only CYCLES clock edges after launch, so the path can legally be constrained with set_multicycle_path -setup CYCLES. A valid/ready handshake sits on both ends, and a capture-to-through feedback path exists for every lane.

---
 rtl/set_multicycle_path_pkg.sv | 24 ++
 rtl/mcp_lane.sv | 59 +++++
 rtl/set_multicycle_path_param.sv | 128 ++++++++++++
 3 files changed

// File: rtl/set_multicycle_path_pkg.sv
// Shared types and helpers for the multicycle-path benchmark block.
package set_multicycle_path_pkg;

    // Launch/capture sequencing states shared by all lanes
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } mcp_state_e;

    // Through-logic selectors
    localparam int MODE_AND = 0;
    localparam int MODE_ADD = 1;

    // Counter width: enough bits to hold CYCLES-1, never narrower than one bit
    function automatic int mcp_cnt_w(input int cycles);
        if (cycles <= 1) begin
            return 1;
        end else begin
            return $clog2(cycles);
        end
    endfunction

endpackage

// File: rtl/mcp_lane.sv
// One data lane: launch register, combinational through stage, capture
// register and the feedback register that closes the capture-to-through loop.
module mcp_lane
    import set_multicycle_path_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MODE  = MODE_AND
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             capture,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    logic [WIDTH-1:0] r_launch_q;
    logic [WIDTH-1:0] r_fb_q;
    logic [WIDTH-1:0] r_cap_q;
    logic [WIDTH-1:0] w_thr;

    // Through stage: the multicycle path runs from r_launch_q/r_fb_q to r_cap_q
    always_comb begin
        w_thr = '0;
        if (MODE == MODE_ADD) begin
            w_thr = r_launch_q + r_fb_q;
        end else begin
            w_thr = r_launch_q & r_fb_q;
        end
    end

    // Launch register: changes only on an accepted handshake, never mid-flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_launch_q <= '0;
        end else if (load) begin
            r_launch_q <= d_in;
        end else begin
            r_launch_q <= r_launch_q;
        end
    end

    // Capture and feedback: fb resets to all ones so the first AND is transparent
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cap_q <= '0;
            r_fb_q  <= '1;
        end else if (capture) begin
            r_cap_q <= w_thr;
            r_fb_q  <= ~w_thr;
        end else begin
            r_cap_q <= r_cap_q;
            r_fb_q  <= r_fb_q;
        end
    end

    assign d_out = r_cap_q;

endmodule

// File: rtl/set_multicycle_path_param.sv
// Multicycle-path benchmark top: shared FSM and counter sequencing LANES
// identical lanes so capture happens exactly CYCLES edges after launch.
module set_multicycle_path_param
    import set_multicycle_path_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LANES  = 2,
    parameter int CYCLES = 2,
    parameter int MODE   = MODE_AND
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH*LANES-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH*LANES-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam int               CNT_W    = mcp_cnt_w(CYCLES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CYCLES - 1);

    mcp_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic             r_busy;
    logic             w_load;
    logic             w_capture;
    logic             w_in_ready;

    // Handshake decode: in HOLD the downstream ready passes straight through
    always_comb begin
        w_load     = 1'b0;
        w_capture  = 1'b0;
        w_in_ready = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                w_load     = in_valid;
            end
            WAIT: begin
                w_capture = (r_cnt == '0);
            end
            HOLD: begin
                w_in_ready = out_ready;
                w_load     = out_ready & in_valid;
            end
            default: begin
                w_load     = 1'b0;
                w_capture  = 1'b0;
                w_in_ready = 1'b0;
            end
        endcase
    end

    // Sequencer: counts launch-to-capture edges and owns out_valid/busy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_cnt   <= CNT_INIT;
                        r_busy  <= 1'b1;
                        r_state <= WAIT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= HOLD;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (in_valid) begin
                            r_cnt   <= CNT_INIT;
                            r_busy  <= 1'b1;
                            r_state <= WAIT;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_state <= HOLD;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= '0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Lanes share load/capture; names stay fixed for -through constraints
    for (genvar k = 0; k < LANES; k++) begin : u_lane
        mcp_lane #(
            .WIDTH (WIDTH),
            .MODE  (MODE)
        ) u_mcp (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (w_load),
            .capture (w_capture),
            .d_in    (in_data[k*WIDTH +: WIDTH]),
            .d_out   (out_data[k*WIDTH +: WIDTH])
        );
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

endmodule
